// File: rtl/core_hazard_ctrl_pkg.sv
// Shared constants for the i2d core hazard controller: 3-bit FSM state codes.
package core_hazard_ctrl_pkg;

  localparam logic [2:0] CORE_HZ_ST_RUN   = 3'd0;
  localparam logic [2:0] CORE_HZ_ST_LDU   = 3'd1;
  localparam logic [2:0] CORE_HZ_ST_MCW   = 3'd2;
  localparam logic [2:0] CORE_HZ_ST_MEMW  = 3'd3;
  localparam logic [2:0] CORE_HZ_ST_FLUSH = 3'd4;
  localparam logic [2:0] CORE_HZ_ST_EXC   = 3'd5;

endpackage

// File: rtl/core_hazard_detect.sv
// Combinational load-use hazard compare between the ID sources and the EX load destination.
module core_hazard_detect #(
  parameter int RF_AW = 5
) (
  input  logic             id_valid,
  input  logic [RF_AW-1:0] id_ra_addr,
  input  logic [RF_AW-1:0] id_rb_addr,
  input  logic             id_use_ra,
  input  logic             id_use_rb,
  input  logic             ex_load,
  input  logic             ex_rd_we,
  input  logic [RF_AW-1:0] ex_rd_addr,
  output logic             hazard
);

  // A load result is only available a cycle late, so any ID read of its destination must wait.
  always_comb begin
    hazard = ex_load && ex_rd_we && id_valid &&
             ((id_use_ra && (id_ra_addr == ex_rd_addr)) ||
              (id_use_rb && (id_rb_addr == ex_rd_addr)));
  end

endmodule

// File: rtl/core_hazard_ctrl.sv
// Pipeline sequencing controller: stall/flush/bubble generation for IF/ID/EX of the i2d core.
module core_hazard_ctrl
  import core_hazard_ctrl_pkg::*;
#(
  parameter int RF_AW     = 5,
  parameter int FLUSH_CYC = 1,
  parameter int MC_MAX    = 64,
  parameter int MC_CW     = 7
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [RF_AW-1:0] id_ra_addr,
  input  logic [RF_AW-1:0] id_rb_addr,
  input  logic             id_use_ra,
  input  logic             id_use_rb,
  input  logic             ex_load,
  input  logic             ex_rd_we,
  input  logic [RF_AW-1:0] ex_rd_addr,
  input  logic             ex_mc_start,
  input  logic             alu_done,
  input  logic             mau_req,
  input  logic             mau_ack,
  input  logic             br_taken,
  input  logic             exc_req,
  output logic             if_halt,
  output logic             id_halt,
  output logic             ex_halt,
  output logic             id_flush,
  output logic             ex_bubble,
  output logic             pc_sel_exc,
  output logic             mc_timeout,
  output logic [2:0]       ctrl_state
);

  localparam int FL_W = (FLUSH_CYC < 1) ? 1 : $clog2(FLUSH_CYC + 1);

  logic [2:0]       state, nxt_state;
  logic [MC_CW-1:0] mc_cnt;
  logic [FL_W-1:0]  fl_cnt;
  logic             ld_hz;
  logic             if_h, id_h, ex_h, fl_o, bub_o, exc_o;
  logic             mc_clr, mc_inc, fl_load, fl_dec, to_set;

  core_hazard_detect #(.RF_AW(RF_AW)) u_detect (
    .id_valid   (id_valid),
    .id_ra_addr (id_ra_addr),
    .id_rb_addr (id_rb_addr),
    .id_use_ra  (id_use_ra),
    .id_use_rb  (id_use_rb),
    .ex_load    (ex_load),
    .ex_rd_we   (ex_rd_we),
    .ex_rd_addr (ex_rd_addr),
    .hazard     (ld_hz)
  );

  // Next-state, per-cycle controls and counter strobes from the current state and inputs.
  always_comb begin
    nxt_state = state;
    if_h      = 1'b0;
    id_h      = 1'b0;
    ex_h      = 1'b0;
    fl_o      = 1'b0;
    bub_o     = 1'b0;
    exc_o     = 1'b0;
    mc_clr    = 1'b0;
    mc_inc    = 1'b0;
    fl_load   = 1'b0;
    fl_dec    = 1'b0;
    to_set    = 1'b0;
    case (state)
      CORE_HZ_ST_RUN: begin
        if (exc_req && id_valid) begin
          nxt_state = CORE_HZ_ST_EXC;
        end else if (br_taken) begin
          fl_o      = 1'b1;
          bub_o     = 1'b1;
          fl_load   = 1'b1;
          nxt_state = CORE_HZ_ST_FLUSH;
        end else if (mau_req && !mau_ack) begin
          if_h      = 1'b1;
          id_h      = 1'b1;
          ex_h      = 1'b1;
          nxt_state = CORE_HZ_ST_MEMW;
        end else if (ex_mc_start) begin
          mc_clr    = 1'b1;
          nxt_state = CORE_HZ_ST_MCW;
        end else if (ld_hz) begin
          if_h      = 1'b1;
          id_h      = 1'b1;
          bub_o     = 1'b1;
          nxt_state = CORE_HZ_ST_LDU;
        end
      end
      CORE_HZ_ST_LDU: nxt_state = CORE_HZ_ST_RUN;
      CORE_HZ_ST_MCW: begin
        if (alu_done) begin
          nxt_state = CORE_HZ_ST_RUN;
        end else begin
          if_h = 1'b1;
          id_h = 1'b1;
          ex_h = 1'b1;
          if (mc_cnt == MC_CW'(MC_MAX - 1)) begin
            to_set    = 1'b1;
            nxt_state = CORE_HZ_ST_EXC;
          end else begin
            mc_inc = 1'b1;
          end
        end
      end
      CORE_HZ_ST_MEMW: begin
        if (mau_ack) begin
          nxt_state = CORE_HZ_ST_RUN;
        end else begin
          if_h = 1'b1;
          id_h = 1'b1;
          ex_h = 1'b1;
        end
      end
      CORE_HZ_ST_EXC: begin
        exc_o     = 1'b1;
        fl_o      = 1'b1;
        bub_o     = 1'b1;
        fl_load   = 1'b1;
        nxt_state = CORE_HZ_ST_FLUSH;
      end
      CORE_HZ_ST_FLUSH: begin
        fl_o  = 1'b1;
        bub_o = 1'b1;
        if (fl_cnt <= FL_W'(1)) nxt_state = CORE_HZ_ST_RUN;
        else                    fl_dec    = 1'b1;
      end
      default: nxt_state = CORE_HZ_ST_RUN;
    endcase
  end

  // State, counters and sticky timeout flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= CORE_HZ_ST_RUN;
      mc_cnt     <= '0;
      fl_cnt     <= '0;
      mc_timeout <= 1'b0;
    end else begin
      state <= nxt_state;
      if (mc_clr)      mc_cnt <= '0;
      else if (mc_inc) mc_cnt <= mc_cnt + 1'b1;
      if (fl_load)     fl_cnt <= FL_W'(FLUSH_CYC);
      else if (fl_dec) fl_cnt <= fl_cnt - 1'b1;
      if (to_set)      mc_timeout <= 1'b1;
    end
  end

  // Outputs are combinational; reset gating keeps them low the instant rst falls.
  always_comb begin
    if_halt    = rst & if_h;
    id_halt    = rst & id_h;
    ex_halt    = rst & ex_h;
    id_flush   = rst & fl_o;
    ex_bubble  = rst & bub_o;
    pc_sel_exc = rst & exc_o;
    ctrl_state = state;
  end

endmodule

// File: tb/tb_core_hazard_ctrl.sv
// Directed testbench for core_hazard_ctrl with hand-computed expectations.
module tb_core_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       id_valid, id_use_ra, id_use_rb;
  logic [4:0] id_ra_addr, id_rb_addr, ex_rd_addr;
  logic       ex_load, ex_rd_we, ex_mc_start, alu_done;
  logic       mau_req, mau_ack, br_taken, exc_req;
  logic       if_halt, id_halt, ex_halt, id_flush, ex_bubble, pc_sel_exc, mc_timeout;
  logic [2:0] ctrl_state;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  core_hazard_ctrl #(.RF_AW(5), .FLUSH_CYC(1), .MC_MAX(64), .MC_CW(7)) dut (
    .clk(clk), .rst(rst),
    .id_valid(id_valid), .id_ra_addr(id_ra_addr), .id_rb_addr(id_rb_addr),
    .id_use_ra(id_use_ra), .id_use_rb(id_use_rb),
    .ex_load(ex_load), .ex_rd_we(ex_rd_we), .ex_rd_addr(ex_rd_addr),
    .ex_mc_start(ex_mc_start), .alu_done(alu_done),
    .mau_req(mau_req), .mau_ack(mau_ack), .br_taken(br_taken), .exc_req(exc_req),
    .if_halt(if_halt), .id_halt(id_halt), .ex_halt(ex_halt), .id_flush(id_flush),
    .ex_bubble(ex_bubble), .pc_sel_exc(pc_sel_exc), .mc_timeout(mc_timeout),
    .ctrl_state(ctrl_state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Expected flags order: {if_halt, id_halt, ex_halt, id_flush, ex_bubble, pc_sel_exc, mc_timeout}
  task automatic ck(input string tag, input logic [2:0] st, input logic [6:0] fl);
    chk(tag, {22'd0, ctrl_state, if_halt, id_halt, ex_halt, id_flush, ex_bubble, pc_sel_exc, mc_timeout},
        {22'd0, st, fl});
  endtask

  task automatic clr_in();
    id_valid = 0; id_use_ra = 0; id_use_rb = 0;
    id_ra_addr = '0; id_rb_addr = '0; ex_rd_addr = '0;
    ex_load = 0; ex_rd_we = 0; ex_mc_start = 0; alu_done = 0;
    mau_req = 0; mau_ack = 0; br_taken = 0; exc_req = 0;
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic set_ldu_hz();
    ex_load = 1; ex_rd_we = 1; ex_rd_addr = 5'd3; id_valid = 1;
    id_use_rb = 1; id_rb_addr = 5'd3; id_use_ra = 1; id_ra_addr = 5'd7;
  endtask

  initial begin
    clr_in();
    rst = 0;
    br_taken = 1;
    #2;
    ck("reset_gated", 3'd0, 7'b0000000);
    br_taken = 0;
    #10 rst = 1;
    nxt();

    // Test 1: load-use on rb
    set_ldu_hz(); settle();
    ck("ldu_stall", 3'd0, 7'b1100100);
    nxt(); settle();
    ck("ldu_state", 3'd1, 7'b0000000);
    nxt(); clr_in(); settle();
    ck("ldu_back_run", 3'd0, 7'b0000000);
    ex_load = 1; ex_rd_we = 1; ex_rd_addr = 5'd5; id_valid = 1;
    id_use_ra = 0; id_ra_addr = 5'd5; id_use_rb = 1; id_rb_addr = 5'd3; settle();
    ck("no_hz_use_masked", 3'd0, 7'b0000000);
    nxt(); clr_in();

    // Test 2: multi-cycle op, done 5 cycles after start
    ex_mc_start = 1; settle();
    ck("mc_start", 3'd0, 7'b0000000);
    nxt(); ex_mc_start = 0;
    for (int i = 1; i <= 4; i++) begin
      settle();
      ck("mc_wait", 3'd2, 7'b1110000);
      nxt();
    end
    alu_done = 1; settle();
    ck("mc_done", 3'd2, 7'b0000000);
    nxt(); alu_done = 0; settle();
    ck("mc_back_run", 3'd0, 7'b0000000);

    // Test 3: multi-cycle timeout
    ex_mc_start = 1; settle();
    nxt(); ex_mc_start = 0;
    for (int i = 0; i < 64; i++) begin
      settle();
      ck("mc_to_wait", 3'd2, 7'b1110000);
      nxt();
    end
    settle();
    ck("to_exc", 3'd5, 7'b0001111);
    nxt(); settle();
    ck("to_flush", 3'd4, 7'b0001101);
    nxt(); settle();
    ck("to_run_sticky", 3'd0, 7'b0000001);

    // Test 4: branch beats load-use; FLUSH ignores br/exc
    set_ldu_hz(); br_taken = 1; settle();
    ck("br_over_ldu", 3'd0, 7'b0001101);
    nxt(); exc_req = 1; settle();
    ck("br_flush", 3'd4, 7'b0001101);
    nxt(); clr_in(); settle();
    ck("br_back_run", 3'd0, 7'b0000001);
    // Exception beats branch
    id_valid = 1; exc_req = 1; br_taken = 1; settle();
    ck("exc_over_br", 3'd0, 7'b0000001);
    nxt(); clr_in(); settle();
    ck("exc_state", 3'd5, 7'b0001111);
    nxt(); settle();
    ck("exc_flush", 3'd4, 7'b0001101);
    nxt(); settle();
    ck("exc_back_run", 3'd0, 7'b0000001);

    // Test 5: memory wait with exc_req deferred
    mau_req = 1; settle();
    ck("mem_enter", 3'd0, 7'b1110001);
    nxt(); id_valid = 1; exc_req = 1; settle();
    ck("memw_hold1", 3'd3, 7'b1110001);
    nxt(); settle();
    ck("memw_hold2", 3'd3, 7'b1110001);
    nxt(); mau_ack = 1; settle();
    ck("memw_ack", 3'd3, 7'b0000001);
    nxt(); mau_req = 0; mau_ack = 0; settle();
    ck("mem_run_exc", 3'd0, 7'b0000001);
    nxt(); exc_req = 0; settle();
    ck("mem_exc", 3'd5, 7'b0001111);
    nxt(); clr_in(); settle();
    ck("mem_flush", 3'd4, 7'b0001101);
    nxt(); settle();
    ck("mem_back_run", 3'd0, 7'b0000001);

    // Test 6: async reset mid-MCW
    ex_mc_start = 1; nxt(); ex_mc_start = 0; nxt();
    settle();
    ck("mcw_pre_rst", 3'd2, 7'b1110001);
    #1 rst = 0; br_taken = 1;
    #1;
    ck("async_rst", 3'd0, 7'b0000000);
    #1 rst = 1; clr_in();
    nxt();
    set_ldu_hz(); settle();
    ck("post_rst_ldu", 3'd0, 7'b1100100);
    nxt(); clr_in(); settle();
    ck("post_rst_ldu_st", 3'd1, 7'b0000000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
